// File: rtl/dmem_responder_if.sv
// Request/response types and the core<->dmem bus bundle used by dmem_responder.
// The core drives mem_i/addr_i; the responder drives mem_o.
package dmem_pkg;

  typedef struct packed {
    logic [31:0] write_data;
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic [31:0] read_data;
    logic        valid;
    logic        yumi;
  } mem_out_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// Handshake: mem_o.yumi acknowledges a request in the same cycle mem_i.valid is high
// (transfer on the rising edge with both high); mem_o.valid stays high with stable
// read_data until the core raises mem_i.yumi at a rising edge.
interface dmem_responder_if #(
  parameter int ADDR_W_P = 12
);
  import dmem_pkg::*;

  mem_in_s             mem_i;
  logic [ADDR_W_P-1:0] addr_i;
  mem_out_s            mem_o;

  modport master (output mem_i, output addr_i, input mem_o);
  modport slave  (input mem_i, input addr_i, output mem_o);

endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding word/byte load/store against an internal
// RAM, with the response presented a fixed number of cycles after the request is taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W_P  = 12,
  parameter int LATENCY_P = 2
) (
  input  logic             clk,
  input  logic             n_reset,
  dmem_responder_if.slave  bus,
  output logic             busy_o,
  output state_e           dbgState
);

  localparam int DEPTH = 2 ** (ADDR_W_P - 2);
  localparam int CNT_W = (LATENCY_P > 1) ? $clog2(LATENCY_P) : 1;

  if (LATENCY_P < 1) begin : gBadLatency
    $error("dmem_responder: LATENCY_P must be at least 1");
  end

  logic [31:0]         ram [DEPTH];
  state_e              stateQ, stateD;
  logic [CNT_W-1:0]    cntQ, cntD;
  logic [31:0]         readDataQ, readDataD;
  logic                accept;
  logic [ADDR_W_P-3:0] wordIdx;
  logic [1:0]          lane;
  logic [31:0]         ramWord;
  logic [31:0]         loadData;

  assign wordIdx = bus.addr_i[ADDR_W_P-1:2];
  assign lane    = bus.addr_i[1:0];
  assign ramWord = ram[wordIdx];

  // Stores respond with zero; byte loads are zero-extended from the addressed lane.
  always_comb begin
    loadData = '0;
    if (!bus.mem_i.wen) begin
      if (bus.mem_i.byte_not_word) begin
        loadData = {24'd0, ramWord[{lane, 3'b000} +: 8]};
      end else begin
        loadData = ramWord;
      end
    end
  end

  always_comb begin
    stateD    = stateQ;
    cntD      = cntQ;
    readDataD = readDataQ;
    accept    = 1'b0;
    bus.mem_o = '0;
    case (stateQ)
      IDLE: begin
        bus.mem_o.yumi = bus.mem_i.valid;
        if (bus.mem_i.valid) begin
          accept    = 1'b1;
          readDataD = loadData;
          cntD      = CNT_W'(LATENCY_P - 1);
          stateD    = (LATENCY_P == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cntD = cntQ - CNT_W'(1);
        if (cntQ == CNT_W'(1)) begin
          stateD = RESP;
        end
      end
      RESP: begin
        bus.mem_o.valid     = 1'b1;
        bus.mem_o.read_data = readDataQ;
        if (bus.mem_i.yumi) begin
          stateD = IDLE;
        end
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stateQ    <= IDLE;
      cntQ      <= '0;
      readDataQ <= '0;
    end else begin
      stateQ    <= stateD;
      cntQ      <= cntD;
      readDataQ <= readDataD;
    end
  end

  // RAM contents survive reset; a request seen while reset is held is not stored.
  always_ff @(posedge clk) begin
    if (accept && n_reset && bus.mem_i.wen) begin
      if (bus.mem_i.byte_not_word) begin
        ram[wordIdx][{lane, 3'b000} +: 8] <= bus.mem_i.write_data[7:0];
      end else begin
        ram[wordIdx] <= bus.mem_i.write_data;
      end
    end
  end

  assign busy_o   = (stateQ != IDLE);
  assign dbgState = stateQ;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: main instance at latency 2, plus latency 1 and 3
// instances for the throughput scenario.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  always #5 clk = ~clk;

  dmem_responder_if #(.ADDR_W_P(12)) bus0 ();
  dmem_responder_if #(.ADDR_W_P(12)) bus1 ();
  dmem_responder_if #(.ADDR_W_P(12)) bus3 ();

  logic   busy0, busy1, busy3;
  state_e st0, st1, st3;

  dmem_responder #(.ADDR_W_P(12), .LATENCY_P(2)) dut0 (
    .clk(clk), .n_reset(n_reset), .bus(bus0), .busy_o(busy0), .dbgState(st0));
  dmem_responder #(.ADDR_W_P(12), .LATENCY_P(1)) dut1 (
    .clk(clk), .n_reset(n_reset), .bus(bus1), .busy_o(busy1), .dbgState(st1));
  dmem_responder #(.ADDR_W_P(12), .LATENCY_P(3)) dut3 (
    .clk(clk), .n_reset(n_reset), .bus(bus3), .busy_o(busy3), .dbgState(st3));

  int checks = 0;
  int errors = 0;

  // Driver: called just after a rising edge; returns at the falling edge where
  // mem_o.valid is first seen, with the measured latency and response data.
  task automatic issue(input logic wen, input logic bnw, input logic [11:0] addr,
                       input logic [31:0] wd, output int lat, output logic [31:0] rdata);
    int waitCnt;
    bus0.mem_i.valid         = 1'b1;
    bus0.mem_i.wen           = wen;
    bus0.mem_i.byte_not_word = bnw;
    bus0.mem_i.write_data    = wd;
    bus0.mem_i.yumi          = 1'b0;
    bus0.addr_i              = addr;
    waitCnt = 0;
    @(negedge clk);
    while (!bus0.mem_o.yumi && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!bus0.mem_o.yumi) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got yumi=%0b required 1", bus0.mem_o.yumi);
    end
    @(posedge clk); #1;
    bus0.mem_i.valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!bus0.mem_o.valid) begin
        checks++;
        if (busy0 !== 1'b1) begin
          errors++;
          $display("FAIL busy_while_pending: got %0b required 1", busy0);
        end
      end
    end while (!bus0.mem_o.valid && lat < 20);
    rdata = bus0.mem_o.read_data;
  endtask

  // Driver: called at a falling edge during RESP; acknowledges on the next edge.
  task automatic release_resp();
    bus0.mem_i.yumi = 1'b1;
    @(posedge clk); #1;
    bus0.mem_i.yumi = 1'b0;
  endtask

  task automatic test_reset();
    bus0.mem_i = '0; bus0.addr_i = '0;
    bus1.mem_i = '0; bus1.addr_i = '0;
    bus3.mem_i = '0; bus3.addr_i = '0;
    n_reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus0.mem_o !== '0) begin
      errors++; $display("FAIL reset_mem_o: got %h required 0", bus0.mem_o);
    end
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %0b required 0", busy0);
    end
    checks++;
    if (st0 !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d required %0d", st0, IDLE);
    end
    n_reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd;
    issue(1'b1, 1'b0, 12'h010, 32'hDEADBEEF, lat, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL sw_latency: got %0d required 2", lat); end
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sw_read_data: got %h required 0", rd); end
    release_resp();
    issue(1'b0, 1'b0, 12'h010, 32'h0, lat, rd);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL lw_latency: got %0d required 2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h required deadbeef", rd); end
    release_resp();
    issue(1'b0, 1'b0, 12'h012, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_unaligned: got %h required deadbeef", rd); end
    release_resp();
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd;
    issue(1'b1, 1'b1, 12'h011, 32'h000000A5, lat, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL sb_read_data: got %h required 0", rd); end
    release_resp();
    issue(1'b0, 1'b0, 12'h010, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'hDEADA5EF) begin errors++; $display("FAIL sb_merge: got %h required deada5ef", rd); end
    release_resp();
    issue(1'b0, 1'b1, 12'h011, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h000000A5) begin errors++; $display("FAIL lbu_lane1: got %h required 000000a5", rd); end
    release_resp();
    issue(1'b0, 1'b1, 12'h013, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h000000DE) begin errors++; $display("FAIL lbu_lane3: got %h required 000000de", rd); end
    release_resp();
    issue(1'b0, 1'b1, 12'h010, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h000000EF) begin errors++; $display("FAIL lbu_lane0: got %h required 000000ef", rd); end
    release_resp();
  endtask

  task automatic test_stray_yumi();
    bus0.mem_i.yumi = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy0 !== 1'b0 || bus0.mem_o !== '0) begin
        errors++; $display("FAIL stray_yumi: got busy=%0b mem_o=%h required 0/0", busy0, bus0.mem_o);
      end
    end
    bus0.mem_i.yumi = 1'b0;
    @(posedge clk); #1;
  endtask

  // Covers the held-response scenario and a store queued behind a pending load.
  task automatic test_hold();
    int lat; int waitCnt; logic [31:0] rd;
    issue(1'b1, 1'b0, 12'h020, 32'h11111111, lat, rd);
    release_resp();
    issue(1'b0, 1'b0, 12'h020, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL hold_first_data: got %h required 11111111", rd); end
    bus0.mem_i.valid         = 1'b1;
    bus0.mem_i.wen           = 1'b1;
    bus0.mem_i.byte_not_word = 1'b0;
    bus0.mem_i.write_data    = 32'h22222222;
    bus0.addr_i              = 12'h020;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus0.mem_o.valid !== 1'b1 || bus0.mem_o.read_data !== 32'h11111111 || bus0.mem_o.yumi !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got valid=%0b data=%h yumi=%0b required 1/11111111/0",
                 i, bus0.mem_o.valid, bus0.mem_o.read_data, bus0.mem_o.yumi);
      end
      @(negedge clk);
    end
    release_resp();
    @(negedge clk);
    checks++;
    if (bus0.mem_o.yumi !== 1'b1 || bus0.mem_o.valid !== 1'b0) begin
      errors++; $display("FAIL idle_accept: got yumi=%0b valid=%0b required 1/0", bus0.mem_o.yumi, bus0.mem_o.valid);
    end
    @(posedge clk); #1;
    bus0.mem_i.valid = 1'b0;
    waitCnt = 0;
    @(negedge clk);
    while (!bus0.mem_o.valid && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checks++;
    if (bus0.mem_o.valid !== 1'b1 || bus0.mem_o.read_data !== 32'h0) begin
      errors++; $display("FAIL queued_sw_resp: got valid=%0b data=%h required 1/0", bus0.mem_o.valid, bus0.mem_o.read_data);
    end
    release_resp();
    issue(1'b0, 1'b0, 12'h020, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h22222222) begin errors++; $display("FAIL lw_after_sw: got %h required 22222222", rd); end
    release_resp();
  endtask

  task automatic test_back_to_back();
    int prev1 = -1; int prev3 = -1; int n1 = 0; int n3 = 0;
    bus1.mem_i = '0; bus3.mem_i = '0;
    bus1.mem_i.valid = 1'b1; bus1.mem_i.yumi = 1'b1; bus1.addr_i = 12'h010;
    bus3.mem_i.valid = 1'b1; bus3.mem_i.yumi = 1'b1; bus3.addr_i = 12'h010;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      if (bus1.mem_o.yumi) begin
        if (prev1 >= 0) begin
          checks++;
          if (cyc - prev1 !== 2) begin errors++; $display("FAIL b2b_lat1_gap: got %0d required 2", cyc - prev1); end
        end
        prev1 = cyc; n1++;
      end
      if (bus3.mem_o.yumi) begin
        if (prev3 >= 0) begin
          checks++;
          if (cyc - prev3 !== 4) begin errors++; $display("FAIL b2b_lat3_gap: got %0d required 4", cyc - prev3); end
        end
        prev3 = cyc; n3++;
      end
    end
    checks++;
    if (n1 !== 12) begin errors++; $display("FAIL b2b_lat1_count: got %0d required 12", n1); end
    checks++;
    if (n3 !== 6) begin errors++; $display("FAIL b2b_lat3_count: got %0d required 6", n3); end
    @(posedge clk); #1;
    bus1.mem_i.valid = 1'b0; bus3.mem_i.valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    bus1.mem_i.yumi = 1'b0; bus3.mem_i.yumi = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || busy3 !== 1'b0) begin
      errors++; $display("FAIL b2b_drain: got busy1=%0b busy3=%0b required 0/0", busy1, busy3);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd;
    issue(1'b1, 1'b0, 12'h040, 32'h12345678, lat, rd);
    release_resp();
    bus0.mem_i.valid = 1'b1;
    bus0.mem_i.wen   = 1'b0;
    bus0.mem_i.byte_not_word = 1'b0;
    bus0.addr_i      = 12'h040;
    @(posedge clk); #1;
    bus0.mem_i.valid = 1'b0;
    checks++;
    if (st0 !== WAIT) begin errors++; $display("FAIL mid_in_wait: got %0d required %0d", st0, WAIT); end
    #1 n_reset = 1'b0;
    #1;
    checks++;
    if (bus0.mem_o !== '0 || busy0 !== 1'b0 || st0 !== IDLE) begin
      errors++; $display("FAIL mid_reset: got mem_o=%h busy=%0b state=%0d required 0/0/0", bus0.mem_o, busy0, st0);
    end
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || bus0.mem_o.valid !== 1'b0) begin
      errors++; $display("FAIL mid_dropped: got busy=%0b valid=%0b required 0/0", busy0, bus0.mem_o.valid);
    end
    @(posedge clk); #1;
    issue(1'b0, 1'b0, 12'h040, 32'h0, lat, rd);
    checks++;
    if (rd !== 32'h12345678 || lat !== 2) begin
      errors++; $display("FAIL mid_reload: got %h lat %0d required 12345678 lat 2", rd, lat);
    end
    release_resp();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_stray_yumi();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule
